// File: rtl/mbist_ijtag_sequencer.sv
// mbist_ijtag_sequencer: on-chip IJTAG host for one MBIST controller assembly BAP.
// Resets the BAP, shifts the setup word into its DR, updates it, then polls by
// capture/shift/update until DONE is captured or the poll budget runs out.
// Optional feature macro: MBIST_SEQ_POLLCNT_EN adds the poll_count output.
module mbist_ijtag_sequencer #(
  parameter int CHAIN_LEN     = 32,
  parameter int RST_CYCLES    = 4,
  parameter int POLL_INTERVAL = 256,
  parameter int MAX_POLLS     = 1024,
  parameter int GO_POS        = 0,
  parameter int DONE_POS      = 1
) (
  input  logic                               tck,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CHAIN_LEN-1:0]               setup_word,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [CHAIN_LEN-1:0]               result_word,
  output logic                               ijtag_reset,
  output logic                               ijtag_select,
  output logic                               ijtag_si,
  output logic                               ijtag_capture_en,
  output logic                               ijtag_shift_en,
  output logic                               ijtag_update_en,
`ifdef MBIST_SEQ_POLLCNT_EN
  output logic [$clog2(MAX_POLLS+1)-1:0]     poll_count,
`endif
  input  logic                               ijtag_so
);

  localparam int CNT_MAX0 = (RST_CYCLES > CHAIN_LEN) ? RST_CYCLES : CHAIN_LEN;
  localparam int CNT_MAX  = (POLL_INTERVAL > CNT_MAX0) ? POLL_INTERVAL : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int PC_W     = $clog2(MAX_POLLS + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [PC_W-1:0]  POLL_LIMIT = PC_W'(MAX_POLLS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_SHIFT,
    S_UPD,
    S_RUN,
    S_CAP,
    S_PSHIFT,
    S_PUPD,
    S_EVAL,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [PC_W-1:0]      r_pollCnt;
  logic [CHAIN_LEN-1:0] r_shReg;
  logic [CHAIN_LEN-2:0] r_capReg;

  logic [PC_W-1:0]      w_pollNext;
  logic [CHAIN_LEN-1:0] w_capNext;
  logic [CHAIN_LEN-1:0] w_shRot;

  assign w_pollNext = r_pollCnt + 1'b1;
  assign w_capNext  = {ijtag_so, r_capReg};
  assign w_shRot    = {r_shReg[0], r_shReg[CHAIN_LEN-1:1]};

`ifdef MBIST_SEQ_POLLCNT_EN
  assign poll_count = r_pollCnt;
`endif

  // Sequencer FSM; every output is registered for the state being entered
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_pollCnt        <= '0;
      r_shReg          <= '0;
      r_capReg         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      result_word      <= '0;
      ijtag_reset      <= 1'b0;
      ijtag_select     <= 1'b0;
      ijtag_si         <= 1'b0;
      ijtag_capture_en <= 1'b0;
      ijtag_shift_en   <= 1'b0;
      ijtag_update_en  <= 1'b0;
    end else begin
      ijtag_reset      <= 1'b0;
      ijtag_select     <= 1'b0;
      ijtag_si         <= 1'b0;
      ijtag_capture_en <= 1'b0;
      ijtag_shift_en   <= 1'b0;
      ijtag_update_en  <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          if (start) begin
            r_shReg     <= setup_word;
            r_cnt       <= '0;
            r_pollCnt   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            result_word <= '0;
            busy        <= 1'b1;
            ijtag_reset <= 1'b1;
            r_state     <= S_RST;
          end
        end
        S_RST: begin
          if (r_cnt == RST_LAST) begin
            r_cnt          <= '0;
            ijtag_select   <= 1'b1;
            ijtag_shift_en <= 1'b1;
            ijtag_si       <= r_shReg[0];
            r_shReg        <= w_shRot;
            r_state        <= S_SHIFT;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            ijtag_reset <= 1'b1;
          end
        end
        S_SHIFT, S_PSHIFT: begin
          ijtag_select <= 1'b1;
          if (r_state == S_PSHIFT) begin
            r_capReg <= w_capNext[CHAIN_LEN-1:1];
          end
          if (r_cnt == SHIFT_LAST) begin
            r_cnt           <= '0;
            ijtag_update_en <= 1'b1;
            if (r_state == S_PSHIFT) begin
              result_word <= w_capNext;
              r_state     <= S_PUPD;
            end else begin
              r_state     <= S_UPD;
            end
          end else begin
            r_cnt          <= r_cnt + 1'b1;
            ijtag_shift_en <= 1'b1;
            ijtag_si       <= r_shReg[0];
            r_shReg        <= w_shRot;
          end
        end
        S_UPD: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_cnt == RUN_LAST) begin
            r_cnt            <= '0;
            ijtag_select     <= 1'b1;
            ijtag_capture_en <= 1'b1;
            r_state          <= S_CAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAP: begin
          r_cnt          <= '0;
          ijtag_select   <= 1'b1;
          ijtag_shift_en <= 1'b1;
          ijtag_si       <= r_shReg[0];
          r_shReg        <= w_shRot;
          r_state        <= S_PSHIFT;
        end
        S_PUPD: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_pollCnt <= w_pollNext;
          if (result_word[DONE_POS]) begin
            done    <= 1'b1;
            pass    <= result_word[GO_POS];
            busy    <= 1'b0;
            r_state <= S_FIN;
          end else if (w_pollNext == POLL_LIMIT) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
